// File: rtl/booth_r4_mult_param_if.sv
// Bus-side signal bundle for the radix-4 Booth multiplier peripheral.
// Handshake: a request transfers on the clk edge where start=1 and start_ready=1.
interface booth_r4_mult_param_if #(
  parameter int WIDTH = 16
);
  logic                 start;
  logic                 start_ready;
  logic                 mode_signed;
  logic [WIDTH-1:0]     data_a;
  logic [WIDTH-1:0]     data_b;
  logic                 abort;
  logic                 irq_enable;
  logic                 ack;
  logic                 busy;
  logic                 done;
  logic                 irq;
  logic [2*WIDTH-1:0]   result;
  logic [1:0]           state_dbg;

  modport master (
    output start, mode_signed, data_a, data_b, abort, irq_enable, ack,
    input  start_ready, busy, done, irq, result, state_dbg
  );

  modport slave (
    input  start, mode_signed, data_a, data_b, abort, irq_enable, ack,
    output start_ready, busy, done, irq, result, state_dbg
  );
endinterface

// File: rtl/booth_r4_mult_param.sv
// Sequential radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, one digit per cycle,
// with abort, persistent result register and irq/busy/ack completion semantics.
module booth_r4_mult_param #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  booth_r4_mult_param_if.slave  bus
);
  localparam int E  = WIDTH + 2;      // extended operand width
  localparam int N  = E / 2;          // number of Booth digits
  localparam int AW = 2 * E + 1;      // accumulator width
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic signed [E:0]      a_q;
  logic [E:0]             b_q;
  logic signed [AW-1:0]   acc_q;
  logic [CW-1:0]          cnt_q;
  logic [2*WIDTH-1:0]     result_q;
  logic                   done_q;
  logic                   irq_q;

  logic                   accept;
  logic                   step;
  logic                   last;
  logic signed [E:0]      pp;
  logic signed [AW-1:0]   pp_al;
  logic signed [AW-1:0]   acc_nxt;
  logic                   sa;
  logic                   sb;

  assign accept = (state == ST_IDLE) && bus.start;
  assign step   = (state == ST_RUN) && !bus.abort;
  assign last   = step && (cnt_q == CW'(N - 1));
  assign sa     = bus.mode_signed & bus.data_a[WIDTH-1];
  assign sb     = bus.mode_signed & bus.data_b[WIDTH-1];

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_RUN;
      ST_RUN: begin
        // abort wins over completion on the same edge
        if (bus.abort)                   state_nxt = ST_IDLE;
        else if (cnt_q == CW'(N - 1))    state_nxt = ST_DONE;
      end
      ST_DONE: if (bus.ack) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // b_q holds {ext_b, 0}; its low three bits are always the current digit.
  always_comb begin
    pp = '0;
    case (b_q[2:0])
      3'b001, 3'b010: pp = a_q;
      3'b011:         pp = a_q <<< 1;
      3'b100:         pp = -(a_q <<< 1);
      3'b101, 3'b110: pp = -a_q;
      default:        pp = '0;
    endcase
  end

  // Partial product enters at the MSBs; after N-1 further shifts digit 0 lands at bit 2.
  assign pp_al   = {pp, {(2 * N){1'b0}}};
  assign acc_nxt = (acc_q >>> 2) + pp_al;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        a_q   <= {{3{sa}}, bus.data_a};
        b_q   <= {{2{sb}}, bus.data_b, 1'b0};
        acc_q <= '0;
        cnt_q <= '0;
      end else if (step) begin
        acc_q <= acc_nxt;
        b_q   <= {b_q[E], b_q[E], b_q[E:2]};
        cnt_q <= cnt_q + CW'(1);
        if (last) begin
          result_q <= acc_nxt[2*WIDTH+1:2];
          done_q   <= 1'b1;
          irq_q    <= bus.irq_enable;
        end
      end
      if ((state == ST_DONE) && bus.ack) irq_q <= 1'b0;
    end
  end

  assign bus.start_ready = (state == ST_IDLE);
  assign bus.busy        = (state != ST_IDLE);
  assign bus.done        = done_q;
  assign bus.irq         = irq_q;
  assign bus.result      = result_q;
  assign bus.state_dbg   = state;
endmodule
